// File: rtl/sdiv_seq.sv
// Sequential radix-2 restoring divider, signed or unsigned.
// One quotient bit per cycle, sign fix-up on the edge into DONE.
module sdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             sgn,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] dm;
    logic             qneg;
    logic             rneg;
    logic             zdiv;

    logic [WIDTH-1:0] nabs;
    logic [WIDTH-1:0] dabs;
    logic [WIDTH:0]   shf;
    logic [WIDTH-1:0] dif;
    logic             ge;

    assign in_rdy  = (state == IDLE);
    assign out_vld = (state == DONE);

    // Operand magnitudes and one restoring step on the widened remainder.
    always_comb begin
        nabs = (sgn && n[WIDTH-1]) ? -n : n;
        dabs = (sgn && d[WIDTH-1]) ? -d : d;
        shf  = {rem, qr[WIDTH-1]};
        ge   = (shf >= {1'b0, dm});
        dif  = shf[WIDTH-1:0] - dm;
    end

    // Control FSM with datapath: accept, iterate WIDTH times, fix up, hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            qr    <= '0;
            dm    <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            zdiv  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_vld) begin
                        state <= CALC;
                        cnt   <= CW'(WIDTH);
                        rem   <= '0;
                        qr    <= nabs;
                        dm    <= dabs;
                        qneg  <= sgn & (n[WIDTH-1] ^ d[WIDTH-1]);
                        rneg  <= sgn & n[WIDTH-1];
                        zdiv  <= (d == '0);
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        rem <= ge ? dif : shf[WIDTH-1:0];
                        qr  <= {qr[WIDTH-2:0], ge};
                    end else begin
                        state <= DONE;
                        q     <= zdiv ? '1 : (qneg ? -qr : qr);
                        r     <= rneg ? -rem : rem;
                        dbz   <= zdiv;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdiv_seq.sv
// Bench for sdiv_seq at WIDTH=32: directed vectors, reset abort,
// random regression, checked every cycle against an arithmetic model.
module tb_sdiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic         sgn = 1'b0;
    logic [W-1:0] n = '0;
    logic [W-1:0] d = '0;
    logic         out_vld;
    logic         out_rdy = 1'b0;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;

    int tests = 0;
    int fails = 0;

    sdiv_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_vld(in_vld),
        .in_rdy(in_rdy),
        .sgn(sgn),
        .n(n),
        .d(d),
        .out_vld(out_vld),
        .out_rdy(out_rdy),
        .q(q),
        .r(r),
        .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Truncating division from plain integer arithmetic.
    function automatic logic [2*W:0] model(input logic s,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic         z;
        longint       sa;
        longint       sb;
        z = 1'b0;
        if (b == 0) begin
            mq = '1;
            mr = a;
            z  = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            mq = W'(sa / sb);
            mr = W'(sa % sb);
        end else begin
            mq = a / b;
            mr = a % b;
        end
        return {z, mq, mr};
    endfunction

    logic         busy = 1'b0;
    int           edges = 0;
    logic [W-1:0] e_q;
    logic [W-1:0] e_r;
    logic         e_z;

    // Transaction timing model: accept, W+1 edges, then wait for consumer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  = 1'b0;
            edges = 0;
        end else if (!busy) begin
            if (in_vld) begin
                {e_z, e_q, e_r} = model(sgn, n, d);
                busy  = 1'b1;
                edges = 0;
            end
        end else if (edges >= W + 1) begin
            if (out_rdy) busy = 1'b0;
        end else begin
            edges++;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_vld", 64'(out_vld), 64'd0);
            chk("rst_q", 64'(q), 64'd0);
            chk("rst_r", 64'(r), 64'd0);
            chk("rst_dbz", 64'(dbz), 64'd0);
            chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        end else begin
            chk("in_rdy", 64'(in_rdy), 64'(!busy));
            chk("out_vld", 64'(out_vld), 64'(busy && edges >= W + 1));
            if (busy && edges >= W + 1) begin
                chk("q", 64'(q), 64'(e_q));
                chk("r", 64'(r), 64'(e_r));
                chk("dbz", 64'(dbz), 64'(e_z));
            end
        end
    end

    task automatic op(input logic s, input logic [W-1:0] a,
                      input logic [W-1:0] b, input int hold,
                      output logic [W-1:0] gq, output logic [W-1:0] gr,
                      output logic gz);
        int k;
        int lat;
        k = 0;
        while (!in_rdy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rdy_wait", 64'(in_rdy), 64'd1);
        sgn     = s;
        n       = a;
        d       = b;
        in_vld  = 1'b1;
        out_rdy = (hold == 0);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        sgn    = 1'($urandom);
        n      = $urandom;
        d      = $urandom;
        lat    = 0;
        while (!out_vld && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(W + 1));
        gq = q;
        gr = r;
        gz = dbz;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_in_rdy", 64'(in_rdy), 64'd0);
            chk("hold_out_vld", 64'(out_vld), 64'd1);
        end
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        chk("idle_in_rdy", 64'(in_rdy), 64'd1);
        chk("idle_out_vld", 64'(out_vld), 64'd0);
    endtask

    task automatic dir(input string name, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input logic [W-1:0] xq,
                       input logic [W-1:0] xr, input logic xz);
        logic [2*W:0] m;
        logic [W-1:0] gq;
        logic [W-1:0] gr;
        logic         gz;
        m = model(s, a, b);
        chk({name, "_model_q"}, 64'(m[2*W-1:W]), 64'(xq));
        chk({name, "_model_r"}, 64'(m[W-1:0]), 64'(xr));
        chk({name, "_model_z"}, 64'(m[2*W]), 64'(xz));
        op(s, a, b, hold, gq, gr, gz);
        chk({name, "_q"}, 64'(gq), 64'(xq));
        chk({name, "_r"}, 64'(gr), 64'(xr));
        chk({name, "_dbz"}, 64'(gz), 64'(xz));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] gq;
        logic [W-1:0] gr;
        logic         gz;

        #2;
        chk("por_out_vld", 64'(out_vld), 64'd0);
        chk("por_in_rdy", 64'(in_rdy), 64'd1);
        chk("por_q", 64'(q), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        dir("neg18_5", 1'b1, 32'hFFFF_FFEE, 32'd5, 10,
            32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0);
        dir("u_ee_5", 1'b0, 32'hFFFF_FFEE, 32'd5, 0,
            32'h3333_332F, 32'd3, 1'b0);
        dir("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2,
            32'h8000_0000, 32'd0, 1'b0);
        dir("s_dbz", 1'b1, 32'd7, 32'd0, 0,
            32'hFFFF_FFFF, 32'd7, 1'b1);
        dir("u_dbz", 1'b0, 32'd7, 32'd0, 0,
            32'hFFFF_FFFF, 32'd7, 1'b1);
        dir("sneg_dbz", 1'b1, 32'hFFFF_FFF9, 32'd0, 0,
            32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        dir("7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0,
            32'hFFFF_FFFD, 32'd1, 1'b0);
        dir("m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0,
            32'd3, 32'hFFFF_FFFF, 1'b0);
        dir("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
            32'd1, 32'd0, 1'b0);
        dir("zero_n", 1'b0, 32'd0, 32'd5, 0,
            32'd0, 32'd0, 1'b0);
        dir("min_1", 1'b1, 32'h8000_0000, 32'd1, 0,
            32'h8000_0000, 32'd0, 1'b0);

        sgn    = 1'b1;
        n      = 32'd1000;
        d      = 32'd3;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_vld", 64'(out_vld), 64'd0);
        chk("abort_q", 64'(q), 64'd0);
        chk("abort_r", 64'(r), 64'd0);
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("post_rst_out_vld", 64'(out_vld), 64'd0);
        dir("100_7", 1'b1, 32'd100, 32'd7, 0,
            32'd14, 32'd2, 1'b0);

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: b = '0;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            op(1'($urandom), a, b, $urandom_range(0, 2), gq, gr, gz);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
